// File: rtl/mux_if.sv
// rtl/mux_if.sv - select/data bundle for the 2:1 mux
interface mux_if #(
   parameter int WIDTH = 1
);
   logic             S;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] X;

   modport master (output S, output A, output B, input X);
   modport slave  (input S, input A, input B, output X);
endinterface

// File: rtl/mux.sv
// rtl/mux.sv - 2:1 data selector with optional output register
module mux #(
   parameter int             WIDTH   = 1,
   parameter bit             REG_OUT = 1'b1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic clk,
   input  logic rst,
   mux_if.slave bus
);
   logic [WIDTH-1:0] sel;

   // Unknown select resolves only when both inputs agree.
   always_comb begin
      sel = bus.A;
      case (bus.S)
         1'b0:    sel = bus.A;
         1'b1:    sel = bus.B;
         default: sel = (bus.A == bus.B) ? bus.A : {WIDTH{1'bx}};
      endcase
   end

   generate
      if (REG_OUT) begin : g_reg
         logic [WIDTH-1:0] x_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               x_q <= RST_VAL;
            end else begin
               x_q <= sel;
            end
         end

         assign bus.X = x_q;
      end else begin : g_comb
         assign bus.X = sel;
      end
   endgenerate
endmodule

// File: tb/tb_mux.sv
// tb/tb_mux.sv - scoreboard bench for registered and combinational mux
module tb_mux;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   typedef struct {
      string      tag;
      logic [7:0] exp;
   } exp_t;

   exp_t q1[$];
   exp_t q8[$];

   logic [7:0] sweep_tab [8] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1};

   always #50 clk = ~clk;

   mux_if #(.WIDTH(1)) bus1 ();
   mux_if #(.WIDTH(8)) bus8 ();
   mux_if #(.WIDTH(1)) busc ();

   mux #(.WIDTH(1), .REG_OUT(1'b1), .RST_VAL(1'b0)) dut_r1 (
      .clk(clk), .rst(rst), .bus(bus1.slave)
   );
   mux #(.WIDTH(8), .REG_OUT(1'b1), .RST_VAL(8'h00)) dut_r8 (
      .clk(clk), .rst(rst), .bus(bus8.slave)
   );
   mux #(.WIDTH(1), .REG_OUT(1'b0), .RST_VAL(1'b0)) dut_c1 (
      .clk(clk), .rst(rst), .bus(busc.slave)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive both registered muxes at the falling edge,
   // queue their expectations, compare just after the rising edge.
   task automatic cycle(input string tag, input logic r,
                        input logic s1, input logic a1, input logic b1,
                        input logic s8, input logic [7:0] a8, input logic [7:0] b8,
                        input logic [7:0] exp1);
      exp_t e;
      @(negedge clk);
      rst     = r;
      bus1.S  = s1;
      bus1.A  = a1;
      bus1.B  = b1;
      bus8.S  = s8;
      bus8.A  = a8;
      bus8.B  = b8;
      e.tag = {tag, "_w1"};
      e.exp = exp1;
      q1.push_back(e);
      e.tag = {tag, "_w8"};
      e.exp = r ? 8'h00 : (s8 ? b8 : a8);
      q8.push_back(e);
      @(posedge clk);
      #1;
      e = q1.pop_front();
      check(e.tag, {7'b0, bus1.X}, e.exp);
      e = q8.pop_front();
      check(e.tag, bus8.X, e.exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [2:0] v;
      bus1.S = 1'b0; bus1.A = 1'b0; bus1.B = 1'b0;
      bus8.S = 1'b0; bus8.A = 8'h00; bus8.B = 8'h00;
      busc.S = 1'b0; busc.A = 1'b0; busc.B = 1'b0;

      // reset with S=1, A=0, B=1
      cycle("rst0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h77, 8'd0);
      cycle("rst1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h77, 8'd0);
      cycle("rst_rel", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h77, 8'd1);

      // exhaustive 1-bit sweep
      for (int i = 0; i < 8; i++) begin
         v = i[2:0];
         cycle($sformatf("sweep%0d", i), 1'b0, v[2], v[1], v[0],
               v[0], 8'(i * 17), ~8'(i * 17), sweep_tab[i]);
      end

      // hold: mid-cycle input change must not reach X
      cycle("hold_load", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 8'd1);
      #20;
      bus1.A = 1'b0;
      bus8.A = 8'h5A;
      #1;
      check("hold_w1", {7'b0, bus1.X}, 8'd1);
      check("hold_w8", bus8.X, 8'hA5);
      cycle("hold_next", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 8'h3C, 8'd0);

      // wide data steering
      cycle("wide_a", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C, 8'd0);
      cycle("wide_b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'd0);

      // mid-stream reset with S=1, B=1
      cycle("strm0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'hC3, 8'd1);
      cycle("strm1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'hC3, 8'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_midcycle_w1", {7'b0, bus1.X}, 8'd1);
      check("rst_midcycle_w8", bus8.X, 8'hC3);
      @(posedge clk);
      #1;
      check("strm_rst_w1", {7'b0, bus1.X}, 8'd0);
      check("strm_rst_w8", bus8.X, 8'h00);
      cycle("strm_rel", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'hC3, 8'd1);

      // combinational instance, checked between clock edges
      @(posedge clk);
      #2;
      for (int i = 0; i < 8; i++) begin
         v = i[2:0];
         busc.S = v[2];
         busc.A = v[1];
         busc.B = v[0];
         #1;
         check($sformatf("comb%0d", i), {7'b0, busc.X}, sweep_tab[i]);
         rst = ~rst;
         #1;
         check($sformatf("comb_rst%0d", i), {7'b0, busc.X}, sweep_tab[i]);
      end
      rst = 1'b0;

      if (q1.size() != 0 || q8.size() != 0) begin
         check("queue_drain", 8'(q1.size() + q8.size()), 8'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
